// File: rtl/rf_wport_arbiter.sv
// Round-robin arbiter for the register-file write port, with a one-entry commit stage.
// Define RF_ARB_BYPASS_EN to forward the in-flight commit value to both read ports.
module rf_wport_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  logic                  last;
  logic                  xfer_p0;
  logic                  gnt1_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  // Stage p0: grant selection, purely combinational
  assign req0_ready = req0_valid && (!req1_valid || last == 1'b1);
  assign req1_ready = req1_valid && (!req0_valid || last == 1'b0);
  assign xfer_p0    = req0_ready || req1_ready;
  assign gnt1_p0    = req1_ready;
  assign addr_p0    = gnt1_p0 ? req1_addr : req0_addr;
  assign data_p0    = gnt1_p0 ? req1_data : req0_data;

  // Stage p1: commit register feeding the register-file write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last    <= 1'b1;
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= xfer_p0 && (addr_p0 != '0);
      if (xfer_p0) begin
        last    <= gnt1_p0;
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign rf_wen   = vld_p1;
  assign rf_waddr = addr_p1;
  assign rf_wdata = data_p1;

`ifdef RF_ARB_BYPASS_EN
  assign rdata1 = (vld_p1 && (addr_p1 == raddr1)) ? data_p1 : rf_rdata1;
  assign rdata2 = (vld_p1 && (addr_p1 == raddr2)) ? data_p1 : rf_rdata2;
`else
  logic unused_raddr;
  assign unused_raddr = ^{raddr1, raddr2};
  assign rdata1 = rf_rdata1;
  assign rdata2 = rf_rdata2;
`endif

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Round-robin arbiter that shares the single write port of the 32×32 register file between two writeback requesters: requester 0 (ALU path) and requester 1 (load path). It registers the granted write into a one-entry commit stage that drives the register file's `wen`/`waddr`/`wdata`. It sits between the writeback logic and the register file. Optionally it forwards the in-flight commit-stage value to the two read ports.

## Interface

Parameters:
- `DATA_WIDTH`, 32, register width
- `ADDR_WIDTH`, 5, register index width

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req0_valid`  in  1  ALU write request
- `req0_addr`  in  ADDR_WIDTH  ALU destination register
- `req0_data`  in  DATA_WIDTH  ALU write data
- `req0_ready`  out  1  ALU request granted this cycle
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`  same as above, for the load path
- `rf_wen`  out  1  register-file write enable, registered
- `rf_waddr`  out  ADDR_WIDTH  register-file write address, registered
- `rf_wdata`  out  DATA_WIDTH  register-file write data, registered
- `raddr1`, `raddr2`  in  ADDR_WIDTH  read addresses, also driven to the register file
- `rf_rdata1`, `rf_rdata2`  in  DATA_WIDTH  raw read data from the register file
- `rdata1`, `rdata2`  out  DATA_WIDTH  read data delivered to the datapath

## Operation

- **Transfer rule:** a transfer on requester i happens in a cycle where `reqi_valid && reqi_ready`.
- **Requester obligation:** keep `valid`/`addr`/`data` stable until the transfer.
- **Ready is combinational:**
  - `req0_ready = req0_valid && (!req1_valid || last == 1)`
  - `req1_ready = req1_valid && (!req0_valid || last == 0)`
  - Ready is never high with valid low.
- **Round-robin pointer `last`** (1 bit):
  - Updates to the granted index on every transfer.
  - Holds when there is no transfer.
  - Reset value is 1, so requester 0 wins the first contention.
- **At most one grant per cycle.** The commit stage accepts a new write every cycle, so there is no backpressure from the register file.
- **Commit stage:** on a transfer, the next `rf_waddr`/`rf_wdata` take the granted addr/data.
- **Register 0 suppression:** the next `rf_wen = 1` only if the granted addr is not 0.
  - A write to register 0 is still accepted (ready asserted) but is suppressed.
  - When suppressed, `rf_waddr`/`rf_wdata` still update.
- **No transfer:** the next `rf_wen = 0`; `rf_waddr`/`rf_wdata` hold.
- **Same destination on both requesters:** arbitrated normally. The loser commits one cycle later, so its value is the final one.
- **Reset values:**
  - `rf_wen = 0`, `rf_waddr = 0`, `rf_wdata = 0`, `last = 1`.
  - `req0_ready`/`req1_ready` follow the formula with `last = 1`.
- **Reset mid-operation:** `rf_wen` drops immediately (asynchronously), so a pending commit is lost. Requesters see no ack for that commit.

## Timing

- **Grant to register-file write:** the grant is in cycle N; `rf_wen` is high in cycle N+1; the register file captures at the end of N+1.
- **Worst-case wait:** a requester that holds `valid` is granted within 2 cycles (starvation-free).
- **Back-to-back contention:** grants alternate 0,1,0,1… with one commit per cycle.
- **Read path:** combinational from `raddr*`/`rf_rdata*`/commit stage to `rdata*`.

## Configuration

- Macro `RF_ARB_BYPASS_EN`.
- **Defined:** `rdata1` = `rf_wdata` when `rf_wen && rf_waddr == raddr1`, else `rf_rdata1`. `rdata2` follows the same rule with `raddr2`/`rf_rdata2`.
  - This covers the one cycle in which the commit stage holds data not yet in the register file.
  - Register 0 is never forwarded, since `rf_wen` is 0 for it.
- **Undefined:** `rdata1 = rf_rdata1` and `rdata2 = rf_rdata2` pure passthrough. The datapath must then handle the one-cycle write-to-read gap itself.

## Test plan

- **Reset:** hold `rst_n = 0` with both requesters valid → `rf_wen = 0`, `rf_waddr = 0`, `rf_wdata = 0`. Release reset → the first grant goes to req0.
- **Single request:** req0 alone, addr 5, data 0xDEADBEEF → `req0_ready = 1` in cycle N. In N+1: `rf_wen = 1`, `rf_waddr = 5`, `rf_wdata = 0xDEADBEEF`. In N+2: `rf_wen = 0`.
- **Contention:** both requesters held valid for 4 cycles → grants go 0,1,0,1 and `rf_wen` stays high for 4 consecutive cycles.
  - Same address 7: req0 data 0x1, req1 data 0x2 → the final commit is 0x2.
- **Register 0:** req1 writes addr 0, data 0xFFFF → `req1_ready = 1`, the next `rf_wen = 0`, and `last` becomes 1.
- **Bypass** (with `RF_ARB_BYPASS_EN`): commit addr 3, data 0x55, with `raddr1 = 3` and `rf_rdata1 = 0x11` → `rdata1 = 0x55` in the commit cycle and 0x11 afterwards. Without the macro → `rdata1 = 0x11` throughout.
- **Async reset mid-commit:** assert `rst_n = 0` mid-cycle while `rf_wen = 1` → `rf_wen` falls before the next clock edge.
